// File: rtl/irq_fiq_controller.sv
// rtl/irq_fiq_controller.sv - FIQ/IRQ interrupt controller: sync, pending latch, priority, request/ack/EOI handshake
module irq_fiq_controller #(
   parameter int  N_SRC       = 8,
   parameter int  SYNC_STAGES = 2,
   localparam int ID_W        = $clog2(N_SRC)
) (
   input  logic             clk,
   input  logic             Rst_n,
   input  logic [N_SRC-1:0] src,
   input  logic [N_SRC-1:0] src_en,
   input  logic [N_SRC-1:0] src_edge,
   input  logic [N_SRC-1:0] src_fiq,
   input  logic             CPSR_6,
   input  logic             CPSR_7,
   input  logic             INTA_irq,
   input  logic             INTA_fiq,
   input  logic             EOI_irq,
   input  logic             EOI_fiq,
   output logic             INT_irq,
   output logic             INT_fiq,
   output logic [ID_W-1:0]  irq_id,
   output logic [ID_W-1:0]  fiq_id,
   output logic [N_SRC-1:0] pending
);

   typedef enum logic [1:0] {IDLE, REQ, SVC} state_t;

   logic [SYNC_STAGES-1:0][N_SRC-1:0] sync_q;
   logic [N_SRC-1:0] s, s_d, pend_n, elig_f, elig_i;
   logic [ID_W-1:0]  win_f, win_i, fiq_id_n, irq_id_n;
   state_t           st_f, st_i, st_f_n, st_i_n;
   logic             acc_f, acc_i;

   assign s      = sync_q[SYNC_STAGES-1];
   assign elig_f = pending & src_fiq;
   assign elig_i = pending & ~src_fiq;

   // An IRQ ack only counts while the core can actually see INT_irq.
   assign acc_f = INTA_fiq && (st_f == REQ);
   assign acc_i = INTA_irq && INT_irq && (st_i == REQ);

   always_comb begin
      pend_n = pending;
      for (int i = 0; i < N_SRC; i++) begin
         if (!src_edge[i])
            pend_n[i] = s[i] & src_en[i];
         else if (s[i] && !s_d[i] && src_en[i])
            pend_n[i] = 1'b1;
         else if (!src_en[i] || (acc_f && fiq_id == ID_W'(i)) || (acc_i && irq_id == ID_W'(i)))
            pend_n[i] = 1'b0;
      end
   end

   always_comb begin
      win_f = '0;
      win_i = '0;
      for (int i = N_SRC-1; i >= 0; i--) begin
         if (elig_f[i]) win_f = ID_W'(i);
         if (elig_i[i]) win_i = ID_W'(i);
      end
   end

   function automatic state_t fsm_next(input state_t st, input logic any, input logic mask,
                                       input logic acc, input logic eoi);
      case (st)
         IDLE:    fsm_next = (any && !mask) ? REQ : IDLE;
         REQ:     fsm_next = acc ? SVC : ((mask || !any) ? IDLE : REQ);
         SVC:     fsm_next = eoi ? IDLE : SVC;
         default: fsm_next = IDLE;
      endcase
   endfunction

   // The id tracks the current winner only while requesting; otherwise it is frozen.
   always_comb begin
      st_f_n   = fsm_next(st_f, |elig_f, CPSR_6, acc_f, EOI_fiq);
      st_i_n   = fsm_next(st_i, |elig_i, CPSR_7, acc_i, EOI_irq);
      fiq_id_n = (st_f_n == REQ) ? win_f : fiq_id;
      irq_id_n = (st_i_n == REQ) ? win_i : irq_id;
   end

   always_ff @(posedge clk or negedge Rst_n) begin
      if (!Rst_n) begin
         sync_q  <= '0;
         s_d     <= '0;
         pending <= '0;
         st_f    <= IDLE;
         st_i    <= IDLE;
         INT_fiq <= 1'b0;
         INT_irq <= 1'b0;
         fiq_id  <= '0;
         irq_id  <= '0;
      end else begin
         sync_q  <= {sync_q[SYNC_STAGES-2:0], src};
         s_d     <= s;
         pending <= pend_n;
         st_f    <= st_f_n;
         st_i    <= st_i_n;
         INT_fiq <= (st_f_n == REQ);
         INT_irq <= (st_i_n == REQ) && (st_f_n != REQ);
         fiq_id  <= fiq_id_n;
         irq_id  <= irq_id_n;
      end
   end

endmodule

// File: doc/irq_fiq_controller.md
Name: irq_fiq_controller

Overview:
- Parametrised interrupt request controller for the ARM v7 core.
- Collects N_SRC external interrupt sources and synchronises them to clk.
- Latches edge- or level-type requests and routes each source to the FIQ or IRQ line.
- Masks with CPSR F/I bits, arbitrates by fixed priority, and runs a request/acknowledge/end-of-interrupt handshake with the core, reporting the winning source ID.

Parameters:
- N_SRC, 8, number of interrupt sources (2..32).
- SYNC_STAGES, 2, synchroniser depth per source (>=2).
- ID_W, $clog2(N_SRC), source ID width; derived, not overridden.

Ports:
- clk  in  1  system clock, all state on rising edge.
- Rst_n  in  1  reset, asynchronous, active-low.
- src  in  N_SRC  raw interrupt inputs, asynchronous to clk.
- src_en  in  N_SRC  per-source enable, 1 = enabled.
- src_edge  in  N_SRC  per-source mode: 1 = rising-edge, 0 = level-high.
- src_fiq  in  N_SRC  per-source routing: 1 = FIQ, 0 = IRQ.
- CPSR_6  in  1  F bit, 1 = FIQ masked.
- CPSR_7  in  1  I bit, 1 = IRQ masked.
- INTA_irq  in  1  IRQ acknowledge, single-cycle pulse.
- INTA_fiq  in  1  FIQ acknowledge, single-cycle pulse.
- EOI_irq  in  1  IRQ end-of-interrupt, single-cycle pulse.
- EOI_fiq  in  1  FIQ end-of-interrupt, single-cycle pulse.
- INT_irq  out  1  IRQ request to core, registered.
- INT_fiq  out  1  FIQ request to core, registered.
- irq_id  out  ID_W  winning/serviced IRQ source, registered.
- fiq_id  out  ID_W  winning/serviced FIQ source, registered.
- pending  out  N_SRC  pending register, registered.

Behaviour:
- Reset (Rst_n low, async): synchronisers, pending, both FSMs to IDLE; INT_irq=INT_fiq=0, irq_id=fiq_id=0, pending=0. Release takes effect on the next edge.
- Sync: src passes through SYNC_STAGES flops giving s; s_d is s delayed one cycle.
- Pending, per source i, each edge:
  - Level mode: pending[i] <= s[i] & src_en[i].
  - Edge mode: set on s[i] & ~s_d[i] & src_en[i]; cleared when that channel's INTA is accepted with id==i, or when src_en[i]=0. Set and clear in the same cycle: set wins.
- Eligibility: elig_f = pending & src_fiq; elig_i = pending & ~src_fiq.
- Priority: lowest index wins, independently per channel.
- Per-channel FSM (identical for FIQ and IRQ; mask = CPSR_6 or CPSR_7):
  - IDLE: when elig != 0 and mask = 0, go to REQ; INT <= 1, id <= winner.
  - REQ: id re-evaluated every cycle to the current winner (a higher-priority arrival pre-empts before ack).
    - On INTA: go to SVC, INT <= 0, id frozen, edge pending bit of id cleared.
    - Else if mask = 1 or elig == 0: go to IDLE, INT <= 0, id holds.
    - INTA and mask/elig-drop in the same cycle: INTA wins.
  - SVC: INT held 0 and id frozen, regardless of new pendings. On EOI go to IDLE; the next request may assert the following cycle.
  - INTA outside REQ and EOI outside SVC: ignored, no state change.
- FIQ over IRQ: INT_irq is registered as (irq FSM next state == REQ) & ~(fiq FSM next state == REQ). The IRQ FSM still advances; it is only the output that is suppressed. INTA_irq while INT_irq=0 is ignored.
- Latency, SYNC_STAGES=2: src high before edge 1 gives s high after edge 2, pending after edge 3, INT_x and id after edge 4 (SYNC_STAGES+2 edges).
- After INTA sampled, INT_x is low after that same edge.
- Level sources stay pending through SVC and re-request after EOI if still high.
- Reset mid-service: all state cleared; no EOI is required afterwards.

Test Plan:
- Reset: hold Rst_n=0 with all src high and src_en all ones -> INT_irq=INT_fiq=0, pending=0. After release, level sources raise INT_irq 4 edges later.
- Edge IRQ: src_edge[3]=1, src_fiq[3]=0, pulse src[3] for 1 cycle, CPSR_7=0 -> INT_irq=1 and irq_id=3 after 4 edges. INTA_irq -> INT_irq=0, pending[3]=0. EOI_irq -> IDLE, no re-request.
- Priority and pre-emption: IRQ sources 5 then 2 edge-triggered 2 cycles apart -> irq_id changes 5 -> 2 before ack. Ack gives 2; after EOI, INT_irq re-asserts with irq_id=5.
- FIQ over IRQ: src 1 (FIQ) and src 4 (IRQ) together -> INT_fiq=1, fiq_id=1, INT_irq=0. After INTA_fiq, INT_irq=1 with irq_id=4.
- Masking: CPSR_6=1 with a FIQ pending -> INT_fiq stays 0 and pending[i]=1. Clear CPSR_6 -> INT_fiq=1 one edge later. Set CPSR_6 in REQ -> INT_fiq=0 next edge; INTA in that same cycle still goes to SVC.
- Level/disable: level src[0] held high through SVC -> INT_irq reasserts 1 edge after EOI. Clearing src_en[0] in IDLE -> pending[0]=0 next edge.
